alu_cmd_sequencer: RTL and testbench

//  Sequences byte-serial commands into the ALU core inside tt_um_czlucius_alu.
//  - Collects opcode, operand A and operand B over an 8-bit valid/ready stream.
//  - Holds the operands stable on the ALU inputs, waits the ALU latency, then captures the result and flags.
//  - Presents the captured result on a valid/ready output stream.
//  - Sits between the pin-level input register (ui_in/uio_in) and the ALU core.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_cmd_sequencer.sv | 104 ++++++++++
 tb/tb_alu_cmd_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, flag bit positions and sequencer state encoding.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_CMP = 4'd7;
    localparam logic [3:0] OP_NOT = 4'd8;
    localparam logic [3:0] OP_NEG = 4'd9;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 3;

    // Opcodes whose bit is set take operand A only
    localparam logic [15:0] UNARY_MASK_DEFAULT = 16'h0300;

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StExec,
        StHold
    } seq_state_e;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Collects opcode/A/B bytes, holds them on the ALU inputs for the ALU latency,
// then presents the captured result and flags on a valid/ready stream.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned ALU_LATENCY = 1,
    parameter logic [15:0] UNARY_MASK  = UNARY_MASK_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [3:0]       res_flags,
    output logic             busy,
    output logic             err
);

    localparam int unsigned CntW = $clog2(ALU_LATENCY + 1);

    seq_state_e      state;
    logic [CntW-1:0] cnt;

    assign cmd_ready = ena && ((state == StIdle) || (state == StLoadA) || (state == StLoadB));
    assign busy      = (state != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            cnt       <= '0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_flags <= '0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            if (ena) begin
                unique case (state)
                    StIdle: begin
                        if (cmd_valid) begin
                            if (cmd_data[WIDTH-1:4] != '0) begin
                                err <= 1'b1;
                            end else begin
                                alu_op <= cmd_data[3:0];
                                state  <= StLoadA;
                            end
                        end
                    end
                    StLoadA: begin
                        if (cmd_valid) begin
                            alu_a <= cmd_data;
                            if (UNARY_MASK[alu_op]) begin
                                alu_b <= '0;
                                cnt   <= CntW'(ALU_LATENCY);
                                state <= StExec;
                            end else begin
                                state <= StLoadB;
                            end
                        end
                    end
                    StLoadB: begin
                        if (cmd_valid) begin
                            alu_b <= cmd_data;
                            cnt   <= CntW'(ALU_LATENCY);
                            state <= StExec;
                        end
                    end
                    StExec: begin
                        // Result settles ALU_LATENCY edges after the operands; sample one edge later
                        if (cnt == '0) begin
                            res_data  <= alu_result;
                            res_flags <= alu_flags;
                            res_valid <= 1'b1;
                            state     <= StHold;
                        end else begin
                            cnt <= cnt - CntW'(1);
                        end
                    end
                    StHold: begin
                        if (res_ready) begin
                            res_valid <= 1'b0;
                            state     <= StIdle;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench: two sequencers (ALU latency 1 and 3) driven by directed byte streams.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic ena = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       cmd_valid = '0;
    logic [1:0]       res_ready = '0;
    logic [1:0][7:0]  cmd_data = '0;
    logic [1:0]       cmd_ready, res_valid, busy, err;
    logic [1:0][7:0]  alu_a, alu_b, alu_result, res_data;
    logic [1:0][3:0]  alu_op, alu_flags, res_flags;

    int checks = 0;
    int errors = 0;
    logic [12:0] exp_q[$];  // {dut id, flags, data}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [11:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                              input logic [7:0] b);
        logic [8:0] w;
        logic [7:0] r;
        logic       c;
        logic       v;
        w = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            OP_ADD: begin
                w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            OP_SUB, OP_CMP: begin
                w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8];
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_SHL: begin r = {a[6:0], 1'b0}; c = a[7]; end
            OP_SHR: begin r = {1'b0, a[7:1]}; c = a[0]; end
            OP_NOT: r = ~a;
            OP_NEG: begin r = 8'd0 - a; c = (a != 8'd0); end
            default: r = '0;
        endcase
        return {v, r[7], c, (r == 8'd0), r};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned Lat = (g == 0) ? 1 : 3;
        logic [11:0] pipe [Lat];
        logic [12:0] e;

        always @(posedge clk) begin
            pipe[0] <= alu_model(alu_op[g], alu_a[g], alu_b[g]);
            for (int i = 1; i < Lat; i++) pipe[i] <= pipe[i-1];
        end
        assign alu_flags[g]  = pipe[Lat-1][11:8];
        assign alu_result[g] = pipe[Lat-1][7:0];

        alu_cmd_sequencer #(.WIDTH(8), .ALU_LATENCY(Lat)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .ena        (ena),
            .cmd_valid  (cmd_valid[g]),
            .cmd_ready  (cmd_ready[g]),
            .cmd_data   (cmd_data[g]),
            .alu_op     (alu_op[g]),
            .alu_a      (alu_a[g]),
            .alu_b      (alu_b[g]),
            .alu_result (alu_result[g]),
            .alu_flags  (alu_flags[g]),
            .res_valid  (res_valid[g]),
            .res_ready  (res_ready[g]),
            .res_data   (res_data[g]),
            .res_flags  (res_flags[g]),
            .busy       (busy[g]),
            .err        (err[g])
        );

        // Monitor: a result transfer happens at the next posedge
        always @(negedge clk) begin
            if (rst_n && ena && res_valid[g] && res_ready[g]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result dut%0d: got %h expected none", g, res_data[g]);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("dut%0d_result_id", g), 32'(g), {31'b0, e[12]});
                    chk($sformatf("dut%0d_res_data", g), {24'b0, res_data[g]}, {24'b0, e[7:0]});
                    chk($sformatf("dut%0d_res_flags", g), {28'b0, res_flags[g]}, {28'b0, e[11:8]});
                end
            end
        end
    end

    task automatic send(input int s, input logic [7:0] b);
        int n = 0;
        cmd_valid[s] = 1'b1;
        cmd_data[s]  = b;
        @(negedge clk);
        while (!cmd_ready[s] && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("cmd_accept", {31'b0, cmd_ready[s]}, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid[s] = 1'b0;
    endtask

    task automatic wait_res(input int s, input int lat, input string name);
        int n = 0;
        while (!res_valid[s] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, n, lat);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_cmd_ready_ena0", {31'b0, cmd_ready[0]}, 32'd0);
        chk("rst_outputs", {busy, res_valid, err}, 32'd0);
        chk("rst_res_data", {res_data[0], res_flags[0], alu_op[0]}, 32'd0);
        ena = 1'b1;
        #1;
        chk("rst_cmd_ready_ena1", {31'b0, cmd_ready[0]}, 32'd1);
        step();
        step();
        rst_n = 1'b1;
        step();

        // ADD 5+3, latency 1
        res_ready[0] = 1'b1;
        exp_q.push_back({1'b0, 4'b0000, 8'h08});
        send(0, 8'h00); send(0, 8'h05); send(0, 8'h03);
        wait_res(0, 2, "add_latency");
        step();
        chk("add_back_idle", {res_valid[0], busy[0], cmd_ready[0]}, 32'b001);

        // SUB 3-5 with stalled consumer
        res_ready[0] = 1'b0;
        exp_q.push_back({1'b0, 4'b0110, 8'hFE});
        send(0, 8'h01); send(0, 8'h03); send(0, 8'h05);
        wait_res(0, 2, "sub_latency");
        for (int i = 0; i < 5; i++) begin
            chk("sub_hold", {res_valid[0], res_data[0], cmd_ready[0]}, {1'b1, 8'hFE, 1'b0});
            step();
        end
        chk("sub_operands", {alu_op[0], alu_a[0], alu_b[0]}, {4'h1, 8'h03, 8'h05});
        res_ready[0] = 1'b1;
        step();
        step();
        chk("sub_drop_valid", {31'b0, res_valid[0]}, 32'd0);

        // NOT: unary, no B byte taken
        exp_q.push_back({1'b0, 4'b0000, 8'h5A});
        send(0, 8'h08); send(0, 8'hA5);
        chk("not_no_b", {cmd_ready[0], alu_b[0], alu_a[0]}, {1'b0, 8'h00, 8'hA5});
        wait_res(0, 2, "not_latency");
        exp_q.push_back({1'b0, 4'b1100, 8'h80});
        send(0, 8'h00);
        chk("not_next_opcode", {busy[0], alu_op[0]}, {1'b1, 4'h0});
        send(0, 8'h7F); send(0, 8'h01);
        wait_res(0, 2, "add_ovf_latency");
        step();

        // Illegal opcode, then AND immediately
        send(0, 8'h17);
        chk("illegal_err", {err[0], busy[0]}, 32'b10);
        exp_q.push_back({1'b0, 4'b0000, 8'h30});
        send(0, 8'h02);
        chk("illegal_err_pulse", {err[0], busy[0], alu_op[0]}, {1'b0, 1'b1, 4'h2});
        send(0, 8'hF0); send(0, 8'h3C);
        wait_res(0, 2, "and_latency");
        step();

        // Reset during EXEC discards the command
        send(0, 8'h00); send(0, 8'h11); send(0, 8'h22);
        chk("exec_busy", {busy[0], cmd_ready[0]}, 32'b10);
        rst_n = 1'b0;
        #1;
        chk("midrst_clear", {busy[0], res_valid[0], err[0], cmd_ready[0]}, 32'b0001);
        chk("midrst_regs", {alu_op[0], alu_a[0], alu_b[0]}, 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("midrst_no_result", {res_valid[0], err[0]}, 32'd0);

        // ena drop during HOLD freezes the pending result
        res_ready[0] = 1'b0;
        exp_q.push_back({1'b0, 4'b0100, 8'hF0});
        send(0, 8'h04); send(0, 8'hFF); send(0, 8'h0F);
        wait_res(0, 2, "xor_latency");
        ena = 1'b0;
        res_ready[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("ena0_freeze", {res_valid[0], busy[0], cmd_ready[0], res_data[0]},
                {1'b1, 1'b1, 1'b0, 8'hF0});
        end
        ena = 1'b1;
        step();
        step();
        chk("ena1_delivered", {res_valid[0], busy[0]}, 32'd0);

        // Latency 3 with a gap between A and B
        res_ready[1] = 1'b1;
        exp_q.push_back({1'b1, 4'b0000, 8'h30});
        send(1, 8'h00); send(1, 8'h10);
        for (int i = 0; i < 4; i++) begin
            chk("gap_wait", {cmd_ready[1], busy[1], alu_b[1]}, {1'b1, 1'b1, 8'h00});
            step();
        end
        send(1, 8'h20);
        wait_res(1, 4, "lat3_latency");
        step();
        step();

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
